// File: rtl/gps_translation_mul_arb.sv
// Round-robin arbiter feeding one shared signed-by-unsigned multiplier through a
// two-stage valid pipeline; results return tagged with the issuing requester.
module gps_translation_mul_arb #(
    parameter int NREQ = 4,
    parameter int A_W  = 32,
    parameter int B_W  = 34,
    parameter int P_W  = 65,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*A_W-1:0]   req_a,
    input  logic [NREQ*B_W-1:0]   req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [P_W-1:0]        res_p,
    output logic                  busy
);

    localparam int FULL_W = A_W + B_W + 1;

    // Signed a times zero-extended b, wrapped to the product width.
    function automatic logic [P_W-1:0] mul_trunc(input logic [A_W-1:0] a,
                                                 input logic [B_W-1:0] b);
        logic signed [FULL_W-1:0] a_ext;
        logic signed [FULL_W-1:0] b_ext;
        logic signed [FULL_W-1:0] prod;
        a_ext = {{(FULL_W-A_W){a[A_W-1]}}, a};
        b_ext = {{(FULL_W-B_W){1'b0}}, b};
        prod  = a_ext * b_ext;
        return prod[P_W-1:0];
    endfunction

    logic [ID_W-1:0] rr_q, rr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [A_W-1:0]  s1_a_q, s1_a_d;
    logic [B_W-1:0]  s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [P_W-1:0]  s2_p_q, s2_p_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    logic [NREQ-1:0] grant_s;
    logic [ID_W-1:0] gnt_id_s;
    logic [ID_W-1:0] idx_s;
    logic            any_s;
    logic            s2_load_s;
    logic            accept_s;
    logic            hs_s;
    logic [A_W-1:0]  sel_a_s;
    logic [B_W-1:0]  sel_b_s;

    // Round-robin search starting at the registered pointer.
    always_comb begin
        grant_s  = '0;
        gnt_id_s = '0;
        idx_s    = '0;
        any_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = ID_W'((int'(rr_q) + k) % NREQ);
            if (!any_s && req_valid[idx_s]) begin
                any_s          = 1'b1;
                gnt_id_s       = idx_s;
                grant_s[idx_s] = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign s2_load_s = !s2_valid_q || res_ready;
    assign accept_s  = !s1_valid_q || s2_load_s;
    assign hs_s      = any_s && accept_s;
    assign sel_a_s   = req_a[gnt_id_s*A_W +: A_W];
    assign sel_b_s   = req_b[gnt_id_s*B_W +: B_W];

    // Ready is masked during reset so nothing appears accepted while state is held clear.
    assign req_ready = (hs_s && ap_rst_n) ? grant_s : '0;

    // Next-state for pointer and both pipeline stages.
    always_comb begin
        rr_d       = rr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_id_d    = s2_id_q;

        if (hs_s) begin
            if (gnt_id_s == ID_W'(NREQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_id_s + ID_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end

        if (accept_s) begin
            s1_valid_d = any_s;
            if (any_s) begin
                s1_a_d  = sel_a_s;
                s1_b_d  = sel_b_s;
                s1_id_d = gnt_id_s;
            end else begin
                s1_id_d = s1_id_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // S2 keeps its last product on a bubble so res_p does not toggle needlessly.
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_p_d  = mul_trunc(s1_a_q, s1_b_q);
                s2_id_d = s1_id_q;
            end else begin
                s2_id_d = s2_id_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_id_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_p     = s2_p_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule
